// File: rtl/audioport_irq_ctrl_if.sv
// Interrupt aggregator bus: source requests, configuration, acknowledge and status.
// The master drives requests, configuration and acks; the slave returns pending bits and irq.
interface audioport_irq_ctrl_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] src_in;
    logic             cfg_we;
    logic [N_SRC-1:0] cfg_enable;
    logic [N_SRC-1:0] cfg_edge;
    logic             ack_in;
    logic [N_SRC-1:0] ack_mask;
    logic [N_SRC-1:0] pending_out;
    logic             irq_out;

    modport master (
        output src_in, cfg_we, cfg_enable, cfg_edge, ack_in, ack_mask,
        input  pending_out, irq_out
    );

    modport slave (
        input  src_in, cfg_we, cfg_enable, cfg_edge, ack_in, ack_mask,
        output pending_out, irq_out
    );
endinterface

// File: rtl/audioport_irq_ctrl.sv
// Collects N_SRC interrupt sources into sticky pending bits and a single irq line.
// Latency: src event -> pending 1 cycle, pending -> irq_out 1 more cycle.
// No backpressure; irq_out stays low at least GAP_CYCLES+1 cycles between assertions.
module audioport_irq_ctrl #(
    parameter int N_SRC      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    audioport_irq_ctrl_if.slave  bus
);
    localparam int CW = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ASSERT  = 2'd1;
    localparam logic [1:0] S_HOLDOFF = 2'd2;

    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_edge;
    logic [N_SRC-1:0] r_src_d;
    logic [N_SRC-1:0] r_pending;
    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_irq;

    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_ack_clr;
    logic [N_SRC-1:0] w_dis_clr;
    logic [N_SRC-1:0] w_pending_nxt;
    logic             w_any;
    logic [1:0]       w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    // Edge mode needs a fresh rise; level mode fires whenever the source is high.
    assign w_set         = bus.src_in & (~r_edge | ~r_src_d) & r_enable;
    assign w_ack_clr     = {N_SRC{bus.ack_in}} & bus.ack_mask;
    assign w_dis_clr     = {N_SRC{bus.cfg_we}} & ~bus.cfg_enable;
    // A set beats a same-cycle ack so no event is lost; disabling a source always clears it.
    assign w_pending_nxt = (w_set | (r_pending & ~w_ack_clr)) & ~w_dis_clr;
    assign w_any         = |r_pending;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_ASSERT;
            end
            S_ASSERT: begin
                if (!w_any) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLDOFF;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_HOLDOFF: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable  <= '0;
            r_edge    <= '0;
            r_src_d   <= '0;
            r_pending <= '0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (bus.cfg_we) begin
                r_enable <= bus.cfg_enable;
                r_edge   <= bus.cfg_edge;
            end
            r_src_d   <= bus.src_in;
            r_pending <= w_pending_nxt;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_irq     <= (w_state_nxt == S_ASSERT);
        end
    end

    assign bus.pending_out = r_pending;
    assign bus.irq_out     = r_irq;
endmodule

// File: tb/tb_audioport_irq_ctrl.sv
// Directed vectors for audioport_irq_ctrl; each vector's expected outputs go into a queue
// that an independent monitor pops and compares one clock edge later.
module tb_audioport_irq_ctrl;
    logic clk;
    logic rst_n;

    audioport_irq_ctrl_if #(.N_SRC(4)) bus ();

    audioport_irq_ctrl #(
        .N_SRC      (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         id;
        logic [3:0] pend;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];
    int   vid    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are applied on the falling edge; the expectation describes the state after the next rise.
    task automatic step(input logic rst, input logic [3:0] src, input logic we,
                        input logic [3:0] en, input logic [3:0] edg, input logic ack,
                        input logic [3:0] mask, input logic [3:0] ep, input logic ei);
        exp_t e;
        @(negedge clk);
        rst_n          = rst;
        bus.src_in     = src;
        bus.cfg_we     = we;
        bus.cfg_enable = en;
        bus.cfg_edge   = edg;
        bus.ack_in     = ack;
        bus.ack_mask   = mask;
        e.id   = vid;
        e.pend = ep;
        e.irq  = ei;
        exp_q.push_back(e);
        vid++;
    endtask

    task automatic idle(input logic [3:0] src, input logic [3:0] ep, input logic ei);
        step(1'b1, src, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, ep, ei);
    endtask

    task automatic ack(input logic [3:0] src, input logic [3:0] mask, input logic [3:0] ep, input logic ei);
        step(1'b1, src, 1'b0, 4'h0, 4'h0, 1'b1, mask, ep, ei);
    endtask

    task automatic cfg(input logic [3:0] en, input logic [3:0] edg, input logic [3:0] ep, input logic ei);
        step(1'b1, 4'h0, 1'b1, en, edg, 1'b0, 4'h0, ep, ei);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (bus.pending_out === e.pend && bus.irq_out === e.irq) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: pending=%b irq=%b, expected pending=%b irq=%b",
                         e.id, bus.pending_out, bus.irq_out, e.pend, e.irq);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.src_in     = 4'hF;
        bus.cfg_we     = 1'b0;
        bus.cfg_enable = 4'h0;
        bus.cfg_edge   = 4'h0;
        bus.ack_in     = 1'b0;
        bus.ack_mask   = 4'h0;

        // Reset held with all sources high, then released with nothing enabled.
        step(1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 20; i++) idle(4'hF, 4'h0, 1'b0);

        // Edge mode on source 0: a 5-cycle pulse pends once; ack drops irq two edges later.
        cfg(4'b0001, 4'b0001, 4'h0, 1'b0);
        idle(4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) idle(4'b0001, 4'b0001, 1'b1);
        idle(4'b0000, 4'b0001, 1'b1);
        ack(4'b0000, 4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) idle(4'b0000, 4'b0000, 1'b0);

        // Level mode on source 1: clear, re-pend, irq low exactly 3 cycles.
        cfg(4'b0010, 4'b0000, 4'h0, 1'b0);
        idle(4'b0010, 4'b0010, 1'b0);
        idle(4'b0010, 4'b0010, 1'b1);
        ack(4'b0000, 4'b0010, 4'b0000, 1'b1);
        idle(4'b0010, 4'b0010, 1'b0);
        idle(4'b0010, 4'b0010, 1'b0);
        idle(4'b0010, 4'b0010, 1'b0);
        idle(4'b0010, 4'b0010, 1'b1);
        ack(4'b0010, 4'b0010, 4'b0010, 1'b1);
        ack(4'b0000, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) idle(4'b0000, 4'b0000, 1'b0);

        // Set/ack collision on edge-mode source 2: set wins, irq never drops.
        cfg(4'b0100, 4'b0100, 4'h0, 1'b0);
        idle(4'b0100, 4'b0100, 1'b0);
        idle(4'b0000, 4'b0100, 1'b1);
        ack(4'b0100, 4'b0100, 4'b0100, 1'b1);
        idle(4'b0000, 4'b0100, 1'b1);
        idle(4'b0000, 4'b0100, 1'b1);
        ack(4'b0000, 4'b0100, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) idle(4'b0000, 4'b0000, 1'b0);

        // Partial ack: 0011 -> 0010 with irq held high.
        cfg(4'b0011, 4'b0011, 4'h0, 1'b0);
        idle(4'b0011, 4'b0011, 1'b0);
        idle(4'b0011, 4'b0011, 1'b1);
        ack(4'b0011, 4'b0001, 4'b0010, 1'b1);
        idle(4'b0000, 4'b0010, 1'b1);
        idle(4'b0000, 4'b0010, 1'b1);
        ack(4'b0000, 4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) idle(4'b0000, 4'b0000, 1'b0);

        // Disable all while 1111 pending, then reset during holdoff.
        cfg(4'b1111, 4'b1111, 4'h0, 1'b0);
        idle(4'b1111, 4'b1111, 1'b0);
        idle(4'b0000, 4'b1111, 1'b1);
        cfg(4'b0000, 4'b1111, 4'b0000, 1'b1);
        idle(4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        // Out of reset the FSM must be in IDLE: a new event raises irq without holdoff delay.
        cfg(4'b0001, 4'b0001, 4'h0, 1'b0);
        idle(4'b0001, 4'b0001, 1'b0);
        idle(4'b0001, 4'b0001, 1'b1);

        repeat (2) @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
